// File: rtl/tfhe_pu_pkg.sv
// Shared definitions for the TFHE PU control/status register block:
// register byte offsets, CTRL/STATUS bit positions, AXI response codes,
// the write/read channel state types and a byte-strobe mask helper.
package tfhe_pu_pkg;

  localparam logic [11:0] REG_ID      = 12'h000;
  localparam logic [11:0] REG_CTRL    = 12'h004;
  localparam logic [11:0] REG_STATUS  = 12'h008;
  localparam logic [11:0] REG_SCRATCH = 12'h00C;
  localparam logic [11:0] REG_CYCLES  = 12'h010;
  localparam logic [11:0] REG_OPS     = 12'h014;

  localparam int CTRL_START       = 0;
  localparam int CTRL_SOFT_RST    = 1;
  localparam int CTRL_LED_LSB     = 8;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_DONE      = 1;
  localparam int STATUS_START_ERR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/tfhe_pu_ctrl_regs_sat_counter32.sv
// sat_counter32: up-counter with synchronous clear and enable that sticks
// at all-ones instead of wrapping.
// Ports: clk, rst_n (async, active-low), clr (priority over en), en, count.
module sat_counter32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {DATA_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tfhe_pu_ctrl_regs.sv
// tfhe_pu_ctrl_regs: AXI4-Lite responder for the TFHE PU register file.
// Ports: axi_aclk/axi_aresetn (async active-low); AXI-Lite AW/W/B/AR/R
// channels; pu_start (1-cycle pulse), pu_soft_rst (level), pu_busy and
// pu_done (status inputs from the core); leds driven from CTRL[15:8].
module tfhe_pu_ctrl_regs
  import tfhe_pu_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'h7F4E_0001
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              pu_start,
  output logic              pu_soft_rst,
  input  logic              pu_busy,
  input  logic              pu_done,
  output logic [7:0]        leds
);

  wr_state_t         wstate, wstate_nxt;
  rd_state_t         rstate, rstate_nxt;
  logic              ready_en;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              done_flag, start_err;
  logic [31:0]       scratch, cycles, ops;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd, mask, rd_data;
  logic [3:0]        ws;
  logic [1:0]        rd_resp;
  logic              wr_mapped, wr_ctrl, wr_status, wr_scratch;
  logic              start_req, start_ok, start_bad;

  // Word-address match; the two byte-offset bits are ignored.
  function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [11:0] off);
    return (a & ~ADDR_W'(3)) == ADDR_W'(off);
  endfunction

  // Readies come up one cycle after reset release; a captured channel
  // stays stalled until its partner arrives and the response is taken.
  assign s_axi_awready = ready_en && (wstate == W_IDLE || wstate == W_HAVE_W);
  assign s_axi_wready  = ready_en && (wstate == W_IDLE || wstate == W_HAVE_AW);
  assign s_axi_arready = ready_en && (rstate == R_IDLE);
  assign s_axi_bvalid  = (wstate == W_RESP);
  assign s_axi_rvalid  = (rstate == R_RESP);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  always_comb begin
    wstate_nxt = wstate;
    commit     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_nxt = W_RESP;
          commit     = 1'b1;
        end else if (aw_hs) begin
          wstate_nxt = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        wstate_nxt = W_RESP;
        commit     = 1'b1;
      end
      W_HAVE_W: if (aw_hs) begin
        wstate_nxt = W_RESP;
        commit     = 1'b1;
      end
      W_RESP: if (s_axi_bready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // The committing beat takes whichever half arrives this cycle live and
  // the other half from its capture register.
  assign wa   = (wstate == W_HAVE_AW) ? awaddr_q : s_axi_awaddr;
  assign wd   = (wstate == W_HAVE_W) ? wdata_q : s_axi_wdata;
  assign ws   = (wstate == W_HAVE_W) ? wstrb_q : s_axi_wstrb;
  assign mask = strb_mask(ws);

  assign wr_mapped  = hit(wa, REG_ID) || hit(wa, REG_CTRL) || hit(wa, REG_STATUS) ||
                      hit(wa, REG_SCRATCH) || hit(wa, REG_CYCLES) || hit(wa, REG_OPS);
  assign wr_ctrl    = commit && hit(wa, REG_CTRL);
  assign wr_status  = commit && hit(wa, REG_STATUS);
  assign wr_scratch = commit && hit(wa, REG_SCRATCH);

  // START is judged against the SOFT_RST value held before this write.
  assign start_req = wr_ctrl && ws[0] && wd[CTRL_START];
  assign start_ok  = start_req && !pu_busy && !pu_soft_rst;
  assign start_bad = start_req && !start_ok;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (hit(s_axi_araddr, REG_ID)) begin
      rd_data = ID_VALUE;
    end else if (hit(s_axi_araddr, REG_CTRL)) begin
      rd_data[CTRL_SOFT_RST]       = pu_soft_rst;
      rd_data[CTRL_LED_LSB +: 8]   = leds;
    end else if (hit(s_axi_araddr, REG_STATUS)) begin
      rd_data[STATUS_BUSY]      = pu_busy;
      rd_data[STATUS_DONE]      = done_flag;
      rd_data[STATUS_START_ERR] = start_err;
    end else if (hit(s_axi_araddr, REG_SCRATCH)) begin
      rd_data = scratch;
    end else if (hit(s_axi_araddr, REG_CYCLES)) begin
      rd_data = cycles;
    end else if (hit(s_axi_araddr, REG_OPS)) begin
      rd_data = ops;
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ready_en    <= 1'b0;
      wstate      <= W_IDLE;
      rstate      <= R_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      pu_start    <= 1'b0;
      pu_soft_rst <= 1'b0;
      leds        <= '0;
      scratch     <= '0;
      done_flag   <= 1'b0;
      start_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      wstate   <= wstate_nxt;
      rstate   <= rstate_nxt;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      pu_start <= start_ok;
      if (commit) s_axi_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      if (wr_scratch) scratch <= (scratch & ~mask) | (wd & mask);
      if (wr_ctrl && ws[0]) pu_soft_rst <= wd[CTRL_SOFT_RST];
      if (wr_ctrl && ws[1]) leds <= wd[CTRL_LED_LSB +: 8];
      // A completion in the same cycle as a clear leaves DONE set.
      if (pu_done) begin
        done_flag <= 1'b1;
      end else if (start_ok || (wr_status && ws[0] && wd[STATUS_DONE])) begin
        done_flag <= 1'b0;
      end
      if (start_bad) begin
        start_err <= 1'b1;
      end else if (wr_status && ws[0] && wd[STATUS_START_ERR]) begin
        start_err <= 1'b0;
      end
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end
  end

  sat_counter32 #(.DATA_W(32)) u_cycles (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .clr   (start_ok),
    .en    (pu_busy),
    .count (cycles)
  );

  sat_counter32 #(.DATA_W(32)) u_ops (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .clr   (1'b0),
    .en    (pu_done),
    .count (ops)
  );

endmodule

// File: tb/tb_tfhe_pu_ctrl_regs.sv
// Self-checking bench for tfhe_pu_ctrl_regs: a vector table, hand-written
// start/done/reset sequences and a randomized phase against a register
// level model of the host-visible behaviour.
module tb_tfhe_pu_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        pu_start, pu_soft_rst;
  logic        pu_busy = 1'b0, pu_done = 1'b0;
  logic [7:0]  leds;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  // Model state
  logic [31:0] m_scratch, m_cycles, m_ops;
  logic [7:0]  m_led;
  logic        m_soft, m_done, m_err;
  bit          cyc_known;
  int          m_starts;

  always #5 clk = ~clk;

  // Count start pulses a little after each edge, so a pulse wider than one
  // cycle is counted more than once.
  always @(posedge clk) begin
    #2;
    if (pu_start === 1'b1) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  tfhe_pu_ctrl_regs dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .pu_start(pu_start), .pu_soft_rst(pu_soft_rst), .pu_busy(pu_busy), .pu_done(pu_done),
    .leds(leds)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = '0; m_cycles = '0; m_ops = '0; m_led = '0;
    m_soft = 1'b0; m_done = 1'b0; m_err = 1'b0; cyc_known = 1'b1;
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    d = '0;
    case (a & 12'hFFC)
      12'h000: d = 32'h7F4E_0001;
      12'h004: d = {16'h0, m_led, 6'b0, m_soft, 1'b0};
      12'h008: d = {29'b0, m_err, m_done, pu_busy};
      12'h00C: d = m_scratch;
      12'h010: d = m_cycles;
      12'h014: d = m_ops;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit done_pulse, output logic [1:0] resp);
    logic [31:0] mask;
    resp = 2'b00;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    case (a & 12'hFFC)
      12'h000, 12'h010, 12'h014: ;
      12'h004: begin
        if (s[0] && d[0]) begin
          if (!pu_busy && !m_soft) begin
            m_starts++; m_cycles = '0; cyc_known = 1'b1; m_done = 1'b0;
          end else begin
            m_err = 1'b1;
          end
        end
        if (s[0]) m_soft = d[1];
        if (s[1]) m_led = d[15:8];
      end
      12'h008: begin
        if ((d & mask) & 32'h2) m_done = 1'b0;
        if ((d & mask) & 32'h4) m_err = 1'b0;
      end
      12'h00C: m_scratch = (m_scratch & ~mask) | (d & mask);
      default: resp = 2'b10;
    endcase
    if (done_pulse) begin
      m_done = 1'b1;
      m_ops++;
    end
  endtask

  // Called at a falling edge. aw_at/w_at: cycle offsets for each channel.
  // bdly<0 leaves the response pending with bready low.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_at, input int w_at, input int bdly, input bit done_pulse,
                           output logic [1:0] resp);
    bit aw_ok;
    bit w_ok;
    int c;
    logic [1:0] held;
    aw_ok = 0; w_ok = 0; c = 0;
    resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_ok && w_ok) && c < 40) begin
      awvalid = !aw_ok && (c >= aw_at);
      wvalid  = !w_ok && (c >= w_at);
      #1;
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      if (aw_ok && w_ok && done_pulse) pu_done = 1'b1;
      @(negedge clk);
      pu_done = 1'b0;
      c++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) begin
      chk("write_handshake_timeout", 32'(c), 32'(0));
      return;
    end
    chk("bvalid_latency", 32'(bvalid), 32'(1));
    chk("ready_low_in_resp", {30'b0, awready, wready}, 32'h0);
    if (bdly < 0) return;
    held = bresp;
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {29'b0, bvalid, bresp}, {29'b0, 1'b1, held});
    end
    bready = 1'b1;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'(0));
  endtask

  task automatic axi_read(input logic [11:0] a, input int rdly,
                          output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    int c;
    ok = 0; c = 0;
    d = 'x; resp = 2'b11;
    araddr = a;
    while (!ok && c < 40) begin
      arvalid = 1'b1;
      #1;
      if (arready) ok = 1;
      @(negedge clk);
      c++;
    end
    arvalid = 1'b0;
    if (!ok) begin
      chk("read_handshake_timeout", 32'(c), 32'(0));
      return;
    end
    chk("rvalid_latency", 32'(rvalid), 32'(1));
    d = rdata; resp = rresp;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rdata_hold", {rvalid, rresp, rdata[28:0]}, {1'b1, resp, d[28:0]});
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'(0));
  endtask

  task automatic wr_do(input string nm, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int aw_at, input int w_at, input int bdly,
                       input bit done_pulse);
    logic [1:0] er, r;
    model_write(a, d, s, done_pulse, er);
    axi_write(a, d, s, aw_at, w_at, bdly, done_pulse, r);
    chk({nm, "_bresp"}, 32'(r), 32'(er));
    chk({nm, "_outputs"}, {23'b0, pu_soft_rst, leds}, {23'b0, m_soft, m_led});
    chk({nm, "_start_count"}, 32'(start_cnt), 32'(m_starts));
  endtask

  task automatic rd_do(input string nm, input logic [11:0] a, input int rdly);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    model_read(a, ed, er);
    axi_read(a, rdly, d, r);
    chk({nm, "_rresp"}, 32'(r), 32'(er));
    if (((a & 12'hFFC) != 12'h010) || cyc_known) chk({nm, "_rdata"}, d, ed);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_at;
    int          w_at;
    int          dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [31:0] d;
    logic [1:0]  r, er;
    logic [11:0] a;
    int          s0, k;

    vt[0]  = '{0, 12'h000, 32'h0, 4'h0, 0, 0, 0, 32'h7F4E_0001, 2'b00};
    vt[1]  = '{1, 12'h00C, 32'hA5A5_A5A5, 4'b0101, 3, 0, 4, 32'h0, 2'b00};
    vt[2]  = '{0, 12'h00C, 32'h0, 4'h0, 0, 0, 2, 32'h00A5_00A5, 2'b00};
    vt[3]  = '{1, 12'h00C, 32'h1234_5678, 4'b1010, 0, 2, 1, 32'h0, 2'b00};
    vt[4]  = '{0, 12'h00C, 32'h0, 4'h0, 0, 0, 0, 32'h12A5_56A5, 2'b00};
    vt[5]  = '{0, 12'h040, 32'h0, 4'h0, 0, 0, 1, 32'h0, 2'b10};
    vt[6]  = '{1, 12'h040, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'h0, 2'b10};
    vt[7]  = '{0, 12'h00C, 32'h0, 4'h0, 0, 0, 0, 32'h12A5_56A5, 2'b00};
    vt[8]  = '{1, 12'h000, 32'h0, 4'hF, 1, 1, 0, 32'h0, 2'b00};
    vt[9]  = '{0, 12'h000, 32'h0, 4'h0, 0, 0, 0, 32'h7F4E_0001, 2'b00};
    vt[10] = '{0, 12'h010, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00};
    vt[11] = '{0, 12'h014, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00};
    vt[12] = '{0, 12'h008, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00};
    vt[13] = '{0, 12'h00E, 32'h0, 4'h0, 0, 0, 0, 32'h12A5_56A5, 2'b00};
    vt[14] = '{1, 12'h00C, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 32'h0, 2'b00};
    vt[15] = '{0, 12'h00C, 32'h0, 4'h0, 0, 0, 0, 32'h12A5_56A5, 2'b00};

    model_reset();
    m_starts = 0;

    // Reset state and ready timing
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'b0, awready, wready, arready, bvalid, rvalid, pu_start,
                          pu_soft_rst, leds, bresp, rresp}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", {29'b0, awready, wready, arready}, 32'h0);
    @(negedge clk);
    chk("ready_after_release", {29'b0, awready, wready, arready}, 32'h7);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) begin
        model_write(vt[i].addr, vt[i].data, vt[i].strb, 1'b0, er);
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_at, vt[i].w_at, vt[i].dly, 1'b0, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vt[i].exp_resp));
      end else begin
        axi_read(vt[i].addr, vt[i].dly, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_resp));
      end
    end

    // START accepted, then a 100-cycle busy period and one completion
    s0 = start_cnt;
    wr_do("ctrl_start", 12'h004, 32'h0000_3C01, 4'hF, 0, 0, 0, 1'b0);
    chk("start_one_pulse", 32'(start_cnt - s0), 32'(1));
    chk("leds_value", 32'(leds), 32'h3C);
    pu_busy = 1'b1;
    repeat (100) @(negedge clk);
    pu_busy = 1'b0;
    pu_done = 1'b1;
    @(negedge clk);
    pu_done = 1'b0;
    m_cycles = 32'd100; m_ops = 32'd1; m_done = 1'b1;
    axi_read(12'h010, 0, d, r);
    chk("cycles_after_busy", d, 32'd100);
    axi_read(12'h014, 0, d, r);
    chk("ops_after_done", d, 32'd1);
    axi_read(12'h008, 0, d, r);
    chk("status_after_done", d, 32'h2);

    // START while busy is refused
    s0 = start_cnt;
    pu_busy = 1'b1;
    wr_do("start_busy", 12'h004, 32'h0000_3C01, 4'hF, 1, 0, 0, 1'b0);
    pu_busy = 1'b0;
    cyc_known = 1'b0;
    chk("no_pulse_when_busy", 32'(start_cnt - s0), 32'(0));
    rd_do("status_err_set", 12'h008, 0);
    wr_do("w1c_err", 12'h008, 32'h4, 4'hF, 0, 0, 0, 1'b0);
    axi_read(12'h008, 0, d, r);
    chk("status_err_cleared", d, 32'h2);
    wr_do("w1c_no_strb", 12'h008, 32'h6, 4'h0, 0, 0, 0, 1'b0);
    rd_do("status_strb_guard", 12'h008, 0);

    // START while SOFT_RST held is refused
    wr_do("soft_on", 12'h004, 32'h2, 4'h1, 0, 0, 0, 1'b0);
    wr_do("start_soft", 12'h004, 32'h1, 4'h1, 0, 1, 0, 1'b0);
    rd_do("status_soft_err", 12'h008, 0);
    wr_do("w1c_err2", 12'h008, 32'h4, 4'h1, 0, 0, 0, 1'b0);

    // Completion pulse on the same edge as a DONE clear
    wr_do("w1c_vs_done", 12'h008, 32'h2, 4'h1, 0, 0, 0, 1'b1);
    axi_read(12'h008, 0, d, r);
    chk("done_set_wins", d, 32'h2);
    rd_do("ops_two", 12'h014, 0);
    axi_read(12'h040, 0, d, r);
    chk("unmapped_rd_resp", 32'(r), 32'(2));
    chk("unmapped_rd_data", d, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: wr_do("rnd_scratch", 12'h00C, $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        1: wr_do("rnd_ctrl", 12'h004, $urandom & 32'h0000_FF03, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        2: wr_do("rnd_status", 12'h008, $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        3, 4: begin
          a = 12'($urandom_range(0, 6)) << 2;
          if (a == 12'h018) a = 12'($urandom_range(6, 1023)) << 2;
          a = a | 12'($urandom_range(0, 3));
          rd_do("rnd_read", a, $urandom_range(0, 2));
        end
        default: begin
          a = (12'($urandom_range(6, 1023)) << 2) | 12'($urandom_range(0, 3));
          wr_do("rnd_unmapped", a, $urandom, 4'hF, $urandom_range(0, 3),
                $urandom_range(0, 3), 0, 1'b0);
        end
      endcase
    end

    // Reset while a write response is pending
    wr_do("pre_rst_led", 12'h004, 32'h0000_5502, 4'h3, 0, 0, 0, 1'b0);
    model_write(12'h00C, 32'hFFFF_0000, 4'hF, 1'b0, er);
    axi_write(12'h00C, 32'hFFFF_0000, 4'hF, 0, 0, -1, 1'b0, r);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_bvalid", {21'b0, bvalid, awready, pu_start, pu_soft_rst, leds}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(12'h00C, 0, d, r);
    chk("scratch_after_rst", d, 32'h0);
    rd_do("ctrl_after_rst", 12'h004, 0);
    rd_do("ops_after_rst", 12'h014, 0);
    rd_do("status_after_rst", 12'h008, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tfhe_pu_ctrl_regs.md
# tfhe_pu_ctrl_regs

AXI4-Lite responder that exposes the TFHE processing unit's control/status register file to the host. It sits behind the XDMA AXI-Lite master inside `tfhe_pu_bd`, terminates host register reads and writes, and issues start pulses to the PU core. It also collects done/busy status and performance counters, and drives the board `leds`.

## Interface
- `ADDR_W`, 12: AXI-Lite address width (byte address; bits [1:0] ignored).
- `ID_VALUE`, 32'h7F4E_0001: constant returned by the ID register.
- `axi_aclk`  in  1  sole clock.
- `axi_aresetn`  in  1  reset, asynchronous, active-low.
- `s_axi_awaddr`  in  ADDR_W  write address.
- `s_axi_awvalid` / `s_axi_awready`  in / out  1  AW handshake.
- `s_axi_wdata`  in  32  write data.
- `s_axi_wstrb`  in  4  byte enables.
- `s_axi_wvalid` / `s_axi_wready`  in / out  1  W handshake.
- `s_axi_bresp`  out  2  write response.
- `s_axi_bvalid` / `s_axi_bready`  out / in  1  B handshake.
- `s_axi_araddr`  in  ADDR_W  read address.
- `s_axi_arvalid` / `s_axi_arready`  in / out  1  AR handshake.
- `s_axi_rdata`  out  32  read data.
- `s_axi_rresp`  out  2  read response.
- `s_axi_rvalid` / `s_axi_rready`  out / in  1  R handshake.
- `pu_start`  out  1  one-cycle start pulse to the PU core.
- `pu_soft_rst`  out  1  level soft reset to the PU core.
- `pu_busy`  in  1  PU core busy, level.
- `pu_done`  in  1  PU core completion, one-cycle pulse.
- `leds`  out  8  board LEDs.

## Operation
- Register map (word offsets):
  - 0x00 ID, RO: `ID_VALUE`.
  - 0x04 CTRL:
    - bit0 START, write-1 pulses `pu_start`, reads 0.
    - bit1 SOFT_RST, RW, drives `pu_soft_rst`.
    - bits[15:8] LED, RW, drives `leds`.
  - 0x08 STATUS:
    - bit0 BUSY, RO, live `pu_busy`.
    - bit1 DONE, sticky, W1C.
    - bit2 START_ERR, sticky, W1C.
  - 0x0C SCRATCH, RW, 32 bits.
  - 0x10 CYCLES, RO: busy-cycle counter.
  - 0x14 OPS, RO: done counter.
- Byte strobes:
  - RW fields update only the bytes whose `wstrb` bit is set.
  - W1C clears use `wdata & strb_mask`.
  - The START bit requires `wstrb[0]`.
- Unmapped address (read or write): response SLVERR (2'b10), read data 0, no side effect.
- START:
  - Issued while `pu_busy`=0 and SOFT_RST=0: `pu_start` pulses, CYCLES clears to 0, DONE clears.
  - Otherwise: no pulse, START_ERR sets.
- CYCLES: increments each cycle `pu_busy`=1, saturates at 32'hFFFF_FFFF.
- OPS: increments on each `pu_done` pulse, saturates at 32'hFFFF_FFFF.
- `pu_done` sets DONE. A set in the same cycle as a W1C clear wins.

## Timing
- Reset values:
  - all `*ready`, `bvalid`, `rvalid`, `pu_start`, `pu_soft_rst` = 0; `leds` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - all registers and counters = 0.
- Ready generation:
  - `awready`/`arready` go to 1 one cycle after reset deasserts.
  - `wready` tracks `awready`.
- Write channel FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - AW and W are accepted independently, in either order. A captured channel holds its ready low until the other arrives.
  - Both captured (same cycle or later): the register update and any `pu_start` pulse occur on the next edge, and `bvalid` rises on that same edge (state W_RESP).
  - `bvalid` holds until `bready`, then the FSM returns to W_IDLE. `awready`/`wready` stay 0 throughout W_RESP.
- Read channel FSM, states R_IDLE, R_RESP:
  - `arready`=1 in R_IDLE.
  - On the AR handshake, `rdata`/`rresp` are registered and `rvalid` rises on the next edge.
  - `rvalid`, `rdata` and `rresp` hold stable until `rready`.
- Minimum latency: 1 cycle from the final address/data handshake to `bvalid`/`rvalid`.
- Read and write channels are independent. If a read and a write to the same register complete in the same cycle, the read returns the pre-write value.
- The `pu_done` pulse is counted in the cycle it is present.
- `axi_aresetn` asserted mid-transaction: every FSM returns to idle immediately. Any pending response is dropped and `pu_start` is forced to 0.

## Structure
- Shared package `tfhe_pu_pkg` holds:
  - register offset constants (`REG_ID`…`REG_OPS`);
  - CTRL/STATUS bit-index constants;
  - the `RESP_OKAY`/`RESP_SLVERR` constants;
  - the write and read FSM state typedefs.
- One natural sub-module: `sat_counter32` (clear, enable, saturate), instantiated for CYCLES and OPS.

## Test plan
- Reset, then read 0x00 → `rdata`=32'h7F4E_0001, `rresp`=OKAY, `rvalid` 1 cycle after the AR handshake.
- Write SCRATCH 32'hA5A5_A5A5 with `wstrb`=4'b0101, with W presented 3 cycles before AW → readback 32'h00A5_00A5; `bvalid` 1 cycle after AW; `bready` held low 4 cycles keeps `bvalid` stable.
- Write CTRL 32'h0000_3C01 while `pu_busy`=0 → one `pu_start` pulse, `leds`=8'h3C. Then hold `pu_busy` high 100 cycles and pulse `pu_done` → CYCLES=100, OPS=1, STATUS=32'h2.
- Write START while `pu_busy`=1 → no `pu_start` pulse, STATUS bit2=1. Then W1C STATUS with 32'h4 → STATUS bit2=0.
- W1C DONE in the same cycle as a `pu_done` pulse → DONE remains 1. Read 0x40 → SLVERR, `rdata`=0.
- Assert `axi_aresetn` while `bvalid`=1 → `bvalid`=0 at once and all registers reset. After release, a read of 0x0C returns 0.
